// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding req/ack read at a time, results queued in a show-ahead FIFO.
// pc_hold is released for exactly one cycle per accepted fetch so the PC advances in step.
module instr_fetch_unit #(
   parameter int DEPTH = 4,
   parameter int AW    = 64,
   parameter int IW    = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [AW-1:0] pc,
   output logic          pc_hold,
   input  logic          flush,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [IW-1:0] mem_rdata,
   output logic          instr_valid,
   input  logic          instr_ready,
   output logic [IW-1:0] instr,
   output logic [AW-1:0] instr_pc,
   output logic          fault
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] addr_q;
   logic          fault_q;
   logic [IW-1:0] st_instr [DEPTH];
   logic [AW-1:0] st_pc    [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic          push, pop, start, set_fault;

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      start     = 1'b0;
      set_fault = 1'b0;
      case (state)
         IDLE: begin
            if (!flush) begin
               if (pc[1:0] != 2'b00)
                  set_fault = 1'b1;
               else if (!fault_q && count < CW'(DEPTH)) begin
                  start     = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_nxt = IDLE;
               push      = !flush;
            end else if (flush)
               state_nxt = DROP;
         end
         // the handshake is never withdrawn; wait out the ack and discard it
         DROP: if (mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   assign pop = (count != '0) && instr_ready && !flush;

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q  <= '0;
         fault_q <= 1'b0;
         wp      <= '0;
         rp      <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            st_instr[i] <= '0;
            st_pc[i]    <= '0;
         end
      end else begin
         if (start) addr_q <= pc;
         if (flush)          fault_q <= 1'b0;
         else if (set_fault) fault_q <= 1'b1;
         if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
         end else begin
            if (push) begin
               st_instr[wp] <= mem_rdata;
               st_pc[wp]    <= addr_q;
               wp           <= wp + PW'(1);
            end
            if (pop) rp <= rp + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   assign mem_req     = (state != IDLE);
   assign mem_addr    = addr_q;
   assign pc_hold     = reset | !push;
   assign fault       = fault_q;
   assign instr_valid = (count != '0);
   assign instr       = st_instr[rp];
   assign instr_pc    = st_pc[rp];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, checked against a
// transaction-level model (expected FIFO as a queue, PC register advanced on each accepted fetch).
module tb_instr_fetch_unit;
   localparam int DEPTH = 4;
   localparam int AW    = 64;
   localparam int IW    = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] pc = '0;
   logic          flush = 1'b0;
   logic          mem_ack = 1'b0;
   logic [IW-1:0] mem_rdata = '0;
   logic          instr_ready = 1'b0;
   logic          pc_hold, mem_req, instr_valid, fault;
   logic [AW-1:0] mem_addr, instr_pc;
   logic [IW-1:0] instr;

   instr_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
      .clock(clock), .reset(reset), .pc(pc), .pc_hold(pc_hold), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .instr_pc(instr_pc), .fault(fault)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [IW-1:0] d;
   } ent_t;

   int   compared = 0;
   int   mismatched = 0;
   ent_t q[$];
   ent_t popped[$];
   logic fault_m = 1'b0;
   logic dropping = 1'b0;
   logic [AW-1:0] req_addr = '0;
   int   ack_dly = 1;
   int   resp_age = 0;
   logic force_ack = 1'b0;
   int   reqs = 0;

   function automatic logic [IW-1:0] memword(input logic [AW-1:0] a);
      case (a)
         64'h0:   return 32'hD280_0020;
         64'h4:   return 32'h8B02_0020;
         64'h8:   return 32'hF940_0041;
         default: return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: memory responder at negedge, model update and checks after posedge.
   task automatic cycle();
      logic req_s, ack_s, fl_s, rst_s, flt_prev, acc, popd, can;
      logic [AW-1:0] pc_s;
      int qs;
      @(negedge clock);
      if (reset || !mem_req) begin
         resp_age = 0;
         mem_ack  = force_ack;
      end else begin
         mem_ack  = (resp_age == ack_dly);
         resp_age++;
      end
      mem_rdata = mem_ack ? memword(mem_addr) : 32'hBAD0_BAD0;
      #1;
      req_s = mem_req; ack_s = mem_ack; fl_s = flush; rst_s = reset;
      pc_s = pc; qs = q.size(); flt_prev = fault_m;
      acc  = !rst_s && req_s && ack_s && !fl_s && !dropping;
      popd = !rst_s && !fl_s && instr_ready && qs != 0;
      chk("pc_hold", 64'(pc_hold), 64'(!acc));
      @(posedge clock);
      #1;
      if (rst_s) begin
         q.delete();
         fault_m = 1'b0; dropping = 1'b0; req_addr = '0;
         chk("rst_mem_req", 64'(mem_req), 64'd0);
         chk("rst_mem_addr", mem_addr, 64'd0);
         chk("rst_instr_valid", 64'(instr_valid), 64'd0);
         chk("rst_fault", 64'(fault), 64'd0);
         chk("rst_pc_hold", 64'(pc_hold), 64'd1);
      end else begin
         if (fl_s) q.delete();
         else begin
            if (popd) begin
               popped.push_back(q[0]);
               void'(q.pop_front());
            end
            if (acc) q.push_back('{req_addr, memword(req_addr)});
         end
         if (fl_s) fault_m = 1'b0;
         else if (!req_s && pc_s[1:0] != 2'b00) fault_m = 1'b1;
         if (req_s && ack_s) dropping = 1'b0;
         else if (req_s && fl_s) dropping = 1'b1;
         if (!req_s) begin
            can = !fl_s && !flt_prev && pc_s[1:0] == 2'b00 && qs < DEPTH;
            chk("mem_req_start", 64'(mem_req), 64'(can));
            if (can) begin
               req_addr = pc_s;
               reqs++;
               chk("mem_addr_start", mem_addr, pc_s);
            end
         end else begin
            chk("mem_req_hold", 64'(mem_req), 64'(!ack_s));
            if (!ack_s) chk("mem_addr_hold", mem_addr, req_addr);
         end
         chk("fault", 64'(fault), 64'(fault_m));
         chk("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
         if (q.size() != 0) begin
            chk("instr", 64'(instr), 64'(q[0].d));
            chk("instr_pc", instr_pc, q[0].a);
         end
         // control selects PC+4 whenever pc_hold was released
         if (acc) pc = pc + 64'd4;
      end
   endtask

   task automatic wait_req(input int max);
      int n = 0;
      while (!mem_req && n < max) begin cycle(); n++; end
      chk("wait_req", 64'(mem_req), 64'd1);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (mem_req && n < max) begin cycle(); n++; end
      chk("wait_idle", 64'(mem_req), 64'd0);
   endtask

   initial begin
      int pops, n, r;
      // reset
      reset = 1'b1; pc = '0;
      cycle(); cycle();
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_instr_pc", instr_pc, 64'd0);
      reset = 1'b0;

      // 1: three sequential fetches from 0
      ack_dly = 1; instr_ready = 1'b1; popped.delete();
      repeat (12) cycle();
      chk("t1_count", 64'(popped.size() >= 3), 64'd1);
      if (popped.size() >= 3) begin
         chk("t1_pc0", popped[0].a, 64'h0);
         chk("t1_in0", 64'(popped[0].d), 64'hD280_0020);
         chk("t1_pc1", popped[1].a, 64'h4);
         chk("t1_in1", 64'(popped[1].d), 64'h8B02_0020);
         chk("t1_pc2", popped[2].a, 64'h8);
         chk("t1_in2", 64'(popped[2].d), 64'hF940_0041);
      end

      // 2: decode stalled, FIFO fills, one pop restarts fetch
      instr_ready = 1'b0;
      flush = 1'b1; pc = 64'h40; cycle(); flush = 1'b0;
      reqs = 0;
      repeat (30) cycle();
      chk("t2_reqs", 64'(reqs), 64'd4);
      chk("t2_req_low", 64'(mem_req), 64'd0);
      chk("t2_hold", 64'(pc_hold), 64'd1);
      instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
      chk("t2_still_valid", 64'(instr_valid), 64'd1);
      chk("t2_no_req_yet", 64'(mem_req), 64'd0);
      cycle();
      chk("t2_restart", 64'(mem_req), 64'd1);

      // 3: flush while request waits on a slow ack
      instr_ready = 1'b1;
      wait_idle(20);
      flush = 1'b1; pc = 64'h200; cycle(); flush = 1'b0;
      wait_idle(20);
      ack_dly = 3;
      wait_req(10);
      chk("t3_addr", mem_addr, 64'h200);
      flush = 1'b1; pc = 64'h100; cycle(); flush = 1'b0;
      chk("t3_req_held", 64'(mem_req), 64'd1);
      chk("t3_addr_held", mem_addr, 64'h200);
      wait_idle(10);
      chk("t3_empty", 64'(instr_valid), 64'd0);
      wait_req(5);
      chk("t3_new_addr", mem_addr, 64'h100);

      // 4: flush coincides with ack
      ack_dly = 0;
      wait_idle(10);
      wait_req(5);
      flush = 1'b1; pc = 64'h300; cycle(); flush = 1'b0;
      chk("t4_idle", 64'(mem_req), 64'd0);
      chk("t4_empty", 64'(instr_valid), 64'd0);

      // 5: misaligned PC faults; flush clears it
      ack_dly = 1;
      flush = 1'b1; pc = 64'h6; cycle(); flush = 1'b0;
      wait_idle(10);
      cycle();
      chk("t5_fault", 64'(fault), 64'd1);
      chk("t5_no_req", 64'(mem_req), 64'd0);
      repeat (3) cycle();
      chk("t5_fault_sticky", 64'(fault), 64'd1);
      chk("t5_still_no_req", 64'(mem_req), 64'd0);
      flush = 1'b1; pc = 64'h8; cycle(); flush = 1'b0;
      chk("t5_fault_clr", 64'(fault), 64'd0);
      cycle();
      chk("t5_req", 64'(mem_req), 64'd1);
      chk("t5_addr", mem_addr, 64'h8);

      // 6: push+pop at count 3, then reset mid-request with a late ack
      instr_ready = 1'b0; ack_dly = 2;
      wait_idle(10);
      flush = 1'b1; pc = 64'h400; cycle(); flush = 1'b0;
      n = 0;
      while (!(q.size() == 3 && mem_req && resp_age == ack_dly) && n < 60) begin cycle(); n++; end
      chk("t6_setup", 64'(n < 60), 64'd1);
      instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
      chk("t6_valid", 64'(instr_valid), 64'd1);
      ack_dly = 1000; instr_ready = 1'b1; pops = 0;
      repeat (6) begin
         if (instr_valid) pops++;
         cycle();
      end
      chk("t6_pops", 64'(pops), 64'd3);
      chk("t6_in_req", 64'(mem_req), 64'd1);
      reset = 1'b1; cycle(); reset = 1'b0;
      force_ack = 1'b1; cycle(); force_ack = 1'b0;
      chk("t6_late_ack_empty", 64'(instr_valid), 64'd0);
      ack_dly = 1;
      repeat (5) cycle();

      // random traffic
      repeat (2500) begin
         if (!mem_req) ack_dly = $urandom_range(0, 3);
         instr_ready = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 99);
         if (r < 5) begin
            flush = 1'b1;
            pc = {$urandom(), $urandom()};
            pc[1:0] = (r == 0) ? 2'b10 : 2'b00;
         end
         reset = (r == 99);
         cycle();
         flush = 1'b0; reset = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
